// File: rtl/hsem_ahb_slave_if_if.sv
// ---------------------------------------------------------------------------
// hsem_ahb_slave_if_if
// AHB-Lite bus bundle between the system interconnect and the HSEM slave
// front end.
//
// Signals:
//   hsel       slave select
//   haddr      32-bit byte address
//   htrans     transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//   hwrite     1 = write
//   hsize      transfer size
//   hready     bus-wide ready (previous data phase complete)
//   hwdata     write data (data phase)
//   hrdata     read data returned by the slave
//   hreadyout  slave ready
//   hresp      0 = OKAY, 1 = ERROR
//
// Modports:
//   master  interconnect / bus master side
//   slave   HSEM front end side
// ---------------------------------------------------------------------------
interface hsem_ahb_slave_if_if #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  hsel;
    logic [31:0]           haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    modport master (
        output hsel,
        output haddr,
        output htrans,
        output hwrite,
        output hsize,
        output hready,
        output hwdata,
        input  hrdata,
        input  hreadyout,
        input  hresp
    );

    modport slave (
        input  hsel,
        input  haddr,
        input  htrans,
        input  hwrite,
        input  hsize,
        input  hready,
        input  hwdata,
        output hrdata,
        output hreadyout,
        output hresp
    );

endinterface

// File: rtl/hsem_ahb_slave_if.sv
// ---------------------------------------------------------------------------
// hsem_ahb_slave_if
// AHB-Lite slave front end for the HSEM macrocell. Captures the address
// phase, checks legality, and produces single-cycle wr_en / rd_en strobes
// plus a registered register offset for hsem_regfiles during the data phase.
// Read data from the regfile is passed back on hrdata during a read data
// phase. Illegal transfers optionally get the two-cycle AHB ERROR response.
//
// Configuration macro:
//   HSEM_AHB_ERR_RESP_EN  defined   -> illegal transfers answered with the
//                                      two-cycle ERROR response (ERR1, ERR2)
//                         undefined -> illegal transfers dropped with an
//                                      OKAY zero-wait response; hresp tied 0,
//                                      hreadyout tied 1
//
// Ports:
//   hclk       bus clock, all state on rising edge
//   hreset     asynchronous active-high reset
//   bus        AHB-Lite slave modport (hsel, haddr, htrans, hwrite, hsize,
//              hready, hwdata in; hrdata, hreadyout, hresp out)
//   wr_en      write strobe to regfile, one data-phase cycle
//   rd_en      read strobe to regfile, one data-phase cycle
//   reg_addr   registered register offset
//   reg_wdata  write data to regfile (hwdata passed through)
//   reg_rdata  combinational read data from regfile
// ---------------------------------------------------------------------------
module hsem_ahb_slave_if #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] LAST_OFFSET = ADDR_WIDTH'(8'h44)
) (
    input  logic                  hclk,
    input  logic                  hreset,
    hsem_ahb_slave_if_if.slave    bus,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata
);

    localparam logic [2:0] SIZE_WORD = 3'b010;

`ifdef HSEM_AHB_ERR_RESP_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;
`endif

    state_t state;

    logic accept;
    logic legal;

    // Only the low ADDR_WIDTH address bits and htrans[1] are decoded.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.haddr[31:ADDR_WIDTH], bus.htrans[0]};

    // Address phase qualification: NONSEQ/SEQ to this slave while the bus is ready.
    assign accept = bus.hsel && bus.hready && bus.htrans[1];

    // Word-sized, word-aligned access inside the implemented register window.
    assign legal = (bus.hsize == SIZE_WORD)
                && (bus.haddr[1:0] == 2'b00)
                && (bus.haddr[ADDR_WIDTH-1:0] <= LAST_OFFSET);

`ifdef HSEM_AHB_ERR_RESP_EN
    logic hresp_q;
    logic hreadyout_q;

    // Transfer FSM with registered strobes and response.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state       <= ST_IDLE;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            reg_addr    <= '0;
            hresp_q     <= 1'b0;
            hreadyout_q <= 1'b1;
        end else if (state == ST_ERR1) begin
            // hready is low during ERR1 (we drive it), so advance unconditionally.
            state       <= ST_ERR2;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            hresp_q     <= 1'b1;
            hreadyout_q <= 1'b1;
        end else if (bus.hready) begin
            state       <= ST_IDLE;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            hresp_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            if (accept) begin
                if (legal) begin
                    reg_addr <= bus.haddr[ADDR_WIDTH-1:0];
                    if (bus.hwrite) begin
                        state <= ST_WR;
                        wr_en <= 1'b1;
                    end else begin
                        state <= ST_RD;
                        rd_en <= 1'b1;
                    end
                end else begin
                    // First ERROR cycle stalls the bus so the master can cancel.
                    state       <= ST_ERR1;
                    hresp_q     <= 1'b1;
                    hreadyout_q <= 1'b0;
                end
            end
        end
    end

    assign bus.hresp     = hresp_q;
    assign bus.hreadyout = hreadyout_q;
`else
    // Transfer FSM with registered strobes; illegal transfers are dropped.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            reg_addr <= '0;
        end else if (bus.hready) begin
            state <= ST_IDLE;
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            if (accept && legal) begin
                reg_addr <= bus.haddr[ADDR_WIDTH-1:0];
                if (bus.hwrite) begin
                    state <= ST_WR;
                    wr_en <= 1'b1;
                end else begin
                    state <= ST_RD;
                    rd_en <= 1'b1;
                end
            end
        end
    end

    assign bus.hresp     = 1'b0;
    assign bus.hreadyout = 1'b1;
`endif

    // Write data goes straight through; the regfile commits at the edge ending WR.
    assign reg_wdata = bus.hwdata;

    // Read data is only driven onto the bus during a read data phase.
    assign bus.hrdata = (state == ST_RD) ? reg_rdata : '0;

endmodule

// File: tb/tb_hsem_ahb_slave_if.sv
// ---------------------------------------------------------------------------
// tb_hsem_ahb_slave_if
// Bench for hsem_ahb_slave_if: a bus driver issues directed and random
// AHB-Lite transfers and pushes the expected data-phase response into a
// queue; a monitor pops one entry per data-phase cycle and compares. A small
// register array stands in for hsem_regfiles, and a separate word-array model
// supplies the expected read data.
// ---------------------------------------------------------------------------
module tb_hsem_ahb_slave_if;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 18;
    localparam logic [7:0]  LAST = 8'h44;

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic          resp;
        logic          ready;
        logic [7:0]    addr;
        logic [31:0]   rdata;
        logic [31:0]   wdata;
    } exp_t;

    logic          hclk = 1'b0;
    logic          hreset;
    logic          rf_clr;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata;

    int vectors     = 0;
    int miscompares = 0;

    exp_t        q[$];
    logic [31:0] model_mem [NREG];
    logic [7:0]  model_addr;
    logic [31:0] pend_wdata;
    logic [DW-1:0] rf [NREG];

    always #5 hclk = ~hclk;

    hsem_ahb_slave_if_if #(.DATA_WIDTH(DW)) bus ();

    // Single-slave system: the bus-wide ready is this slave's ready.
    assign bus.hready = bus.hreadyout;

    hsem_ahb_slave_if #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LAST_OFFSET(LAST)
    ) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .bus      (bus),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata)
    );

    // Stand-in register file.
    always @(posedge hclk) begin
        if (rf_clr) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= 32'hA500_0000 | 32'(i);
        end else if (wr_en && (int'(reg_addr[AW-1:2]) < int'(NREG))) begin
            rf[reg_addr[AW-1:2]] <= reg_wdata;
        end
    end

    assign reg_rdata = (int'(reg_addr[AW-1:2]) < int'(NREG)) ? rf[reg_addr[AW-1:2]] : '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one queued expectation per data-phase cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge hclk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_en",     32'(wr_en),         32'(e.wr));
                chk("rd_en",     32'(rd_en),         32'(e.rd));
                chk("hresp",     32'(bus.hresp),     32'(e.resp));
                chk("hreadyout", 32'(bus.hreadyout), 32'(e.ready));
                chk("reg_addr",  32'(reg_addr),      32'(e.addr));
                chk("hrdata",    bus.hrdata,         e.rdata);
                if (e.wr) chk("reg_wdata", reg_wdata, e.wdata);
            end
        end
    end

    // Present one address phase, wait for acceptance, push its expected data phase(s).
    task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
        exp_t e;
        int   n;
        logic acc;
        logic leg;
        bus.hsel   = sel;
        bus.htrans = tr;
        bus.hwrite = wr;
        bus.hsize  = sz;
        bus.haddr  = ad;
        bus.hwdata = pend_wdata;
        n = 0;
        @(negedge hclk);
        while (bus.hreadyout !== 1'b1 && n < 8) begin
            n++;
            @(negedge hclk);
        end
        if (n >= 8) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: hreadyout stuck at %b, expected 1", bus.hreadyout);
        end
        acc = sel && tr[1];
        leg = (sz == 3'd2) && (ad[1:0] == 2'b00) && (ad[7:0] <= LAST);
        e = '0;
        e.ready = 1'b1;
        if (acc && leg) begin
            model_addr = ad[7:0];
            e.addr = model_addr;
            if (wr) begin
                e.wr    = 1'b1;
                e.wdata = wd;
                model_mem[ad[7:2]] = wd;
            end else begin
                e.rd    = 1'b1;
                e.rdata = model_mem[ad[7:2]];
            end
            q.push_back(e);
        end else begin
            e.addr = model_addr;
`ifdef HSEM_AHB_ERR_RESP_EN
            if (acc) begin
                e.resp  = 1'b1;
                e.ready = 1'b0;
                q.push_back(e);
                e.ready = 1'b1;
            end
`endif
            q.push_back(e);
        end
        pend_wdata = wd;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        logic [31:0] ad;
        logic [2:0]  sz;
        for (int i = 0; i < int'(NREG); i++) model_mem[i] = 32'hA500_0000 | 32'(i);
        model_addr = 8'h00;
        pend_wdata = 32'h0;
        hreset     = 1'b1;
        rf_clr     = 1'b1;
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'b010;
        bus.haddr  = 32'h0;
        bus.hwdata = 32'h0;

        // Reset held for three cycles.
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
        chk("rst_hresp",     32'(bus.hresp),     32'd0);
        chk("rst_wr_en",     32'(wr_en),         32'd0);
        chk("rst_rd_en",     32'(rd_en),         32'd0);
        chk("rst_reg_addr",  32'(reg_addr),      32'd0);
        chk("rst_hrdata",    bus.hrdata,         32'd0);
        hreset = 1'b0;
        rf_clr = 1'b0;

        // Reset pulsed during the WR data phase drops the strobe.
        bus.hsel   = 1'b1;
        bus.htrans = 2'b10;
        bus.hwrite = 1'b1;
        bus.haddr  = 32'h0000_0000;
        @(posedge hclk);
        #1;
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        bus.htrans = 2'b00;
        bus.hwdata = 32'hDEAD_BEEF;
        hreset     = 1'b1;
        #1;
        chk("mid_rst_wr_en",     32'(wr_en),         32'd0);
        chk("mid_rst_hreadyout", 32'(bus.hreadyout), 32'd1);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        chk("mid_rst_rf0", rf[0], model_mem[0]);
        model_addr = 8'h00;

        // Directed transfers.
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h08, 32'h0000_0301);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h14, 32'h0000_0201);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h14, 32'h0);
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h05, 32'h1234_5678);
        xfer(1'b1, 2'b10, 1'b0, 3'd0, 32'h04, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h48, 32'h0);
        xfer(1'b1, 2'b01, 1'b1, 3'd2, 32'h00, 32'h5555_5555);
        xfer(1'b1, 2'b00, 1'b1, 3'd2, 32'h00, 32'h6666_6666);
        xfer(1'b0, 2'b10, 1'b1, 3'd2, 32'h00, 32'h7777_7777);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h00, 32'h0);
        xfer(1'b1, 2'b11, 1'b1, 3'd2, 32'h44, 32'hCAFE_F00D);
        xfer(1'b1, 2'b11, 1'b0, 3'd2, 32'h44, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h04, 32'h0);

        // Random transfers.
        for (int i = 0; i < 400; i++) begin
            ad = $urandom;
            if ($urandom_range(0, 4) != 0) ad[7:0] = 8'($urandom_range(0, 19) * 4);
            sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            xfer(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), sz, ad, $urandom);
        end

        repeat (3) xfer(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        repeat (3) @(posedge hclk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
